regfile_cmd_ctrl: RTL and testbench
===================================

// Module: regfile_cmd_ctrl
// PURPOSE
//  Command sequencer for the 4x4 register file (one comb read port, one write port, no write enable:
//  data is written to w_address on every clk edge). Accepts WRITE/READ/MOVE/SWAP commands over a
//  valid/ready handshake, sequences the file's ports, returns one response per command.
//  Sits between the register file and its single client.
// PARAMETERS
//  DW  4  data width of register file / imm / rsp_data
//  AW  2  address width (2**AW registers)
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   reset, asynchronous, active-low
//  cmd_valid     in   1   command valid
//  cmd_ready     out  1   controller accepts command (transfer when valid&ready at clk edge)
//  cmd_op        in   2   00 WRITE, 01 READ, 10 MOVE, 11 SWAP
//  cmd_src       in   AW  source address (READ/MOVE/SWAP)
//  cmd_dst       in   AW  destination address (WRITE/MOVE/SWAP)
//  cmd_imm       in   DW  immediate data (WRITE)
//  rsp_valid     out  1   response valid, held until rsp_ready
//  rsp_ready     in   1   client accepts response
//  rsp_data      out  DW  response data
//  busy          out  1   high in any state except IDLE
//  rf_r_address  out  AW  register file read address
//  rf_w_address  out  AW  register file write address
//  rf_data       out  DW  register file write data
//  rf_q          in   DW  register file read data (comb of rf_r_address)
// BEHAVIOUR
//  States: IDLE, EXEC, SWAP_B, SWAP_C, RESP. Command fields latched on accept.
//  Non-writing cycle rule: rf_w_address == rf_r_address and rf_data == rf_q (self refresh, no change).
//  IDLE/RESP: r=w=0, rf_data=rf_q. cmd_ready=1 only in IDLE; rsp_valid=1 only in RESP.
//  IDLE: cmd_valid -> latch op/src/dst/imm, go EXEC.
//  EXEC WRITE: r=w=dst, rf_data=imm; rsp_data<=imm; -> RESP.
//  EXEC READ: r=w=src, rf_data=rf_q; rsp_data<=rf_q; -> RESP.
//  EXEC MOVE: r=src, w=dst, rf_data=rf_q; rsp_data<=rf_q; -> RESP.
//  EXEC SWAP: r=w=src, rf_data=rf_q; tmp<=rf_q; -> SWAP_B.
//  SWAP_B: r=w=dst, rf_data=tmp; rsp_data<=rf_q (old dst); -> SWAP_C.
//  SWAP_C: r=w=src, rf_data=rsp_data; -> RESP.
//  RESP: hold rsp_valid/rsp_data stable; rsp_ready -> IDLE next edge.
//  Latency (accept at edge k): rsp_valid high after edge k+1 (WRITE/READ/MOVE), k+3 (SWAP).
//  Throughput: new command accepted earliest 1 cycle after response handshake (IDLE re-entry).
//  cmd_valid while not IDLE: ignored, not latched. rsp_ready outside RESP: ignored.
//  src==dst: MOVE and SWAP leave file unchanged; rsp_data = that register's value.
//  Reset (any state, incl. mid-SWAP): state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0,
//   tmp=0, rf addresses 0, rf_data=rf_q; file shares rst_n so all registers read 0.
// TESTING
//  Reset, 20 idle cycles with file preloaded 1,2,3,4 -> contents unchanged, busy=0, cmd_ready=1.
//  WRITE dst=2 imm=4'hA, then READ src=2 -> rsp_data 4'hA one cycle after each accept edge.
//  WRITE r0=5, MOVE src=2 dst=3 -> rsp_data 4'hA; READ r3 -> 4'hA; r2 still 4'hA.
//  SWAP src=0 dst=3 -> rsp_valid 3 cycles after accept, rsp_data 4'hA; then r0=4'hA, r3=4'h5.
//  rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready=0, file unchanged.
//  rst_n low in SWAP_C -> IDLE, rsp_valid=0, all registers 0; SWAP src=dst=1 -> file unchanged.

Source files
------------

// File: rtl/regfile_cmd_ctrl_if.sv
// Client-side command/response handshake for the register file command sequencer.
// master = the single client, slave = regfile_cmd_ctrl.
interface regfile_cmd_ctrl_if #(
    parameter int DW = 4,
    parameter int AW = 2
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [DW-1:0] cmd_imm;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_cmd_ctrl.sv
// Sequences WRITE/READ/MOVE/SWAP commands onto a register file that writes every cycle;
// idle cycles rewrite the addressed register with its own value.
module regfile_cmd_ctrl #(
    parameter int DW = 4,
    parameter int AW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_cmd_ctrl_if.slave    host,
    output logic                 busy,
    output logic [AW-1:0]        rf_r_address,
    output logic [AW-1:0]        rf_w_address,
    output logic [DW-1:0]        rf_data,
    input  logic [DW-1:0]        rf_q
);

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_MOVE  = 2'b10,
        OP_SWAP  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        SWAP_B,
        SWAP_C,
        RESP
    } state_t;

    typedef struct packed {
        op_t           op;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [DW-1:0] imm;
    } cmd_t;

    state_t        state, state_next;
    cmd_t          cmd_q;
    logic [DW-1:0] tmp;
    logic [DW-1:0] rsp_data_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: datapath registers are reset too, so a reset mid-SWAP leaves no stale tmp/response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            tmp        <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (host.cmd_valid)
                    cmd_q <= '{op: op_t'(host.cmd_op), src: host.cmd_src,
                               dst: host.cmd_dst, imm: host.cmd_imm};
                EXEC: case (cmd_q.op)
                    OP_WRITE:         rsp_data_q <= cmd_q.imm;
                    OP_READ, OP_MOVE: rsp_data_q <= rf_q;
                    OP_SWAP:          tmp        <= rf_q;
                endcase
                SWAP_B:  rsp_data_q <= rf_q;  // old destination value becomes the response
                default: ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next   = state;
        rf_r_address = '0;
        rf_w_address = '0;
        rf_data      = rf_q;
        case (state)
            IDLE: if (host.cmd_valid) state_next = EXEC;
            EXEC: begin
                state_next = RESP;
                case (cmd_q.op)
                    OP_WRITE: begin
                        rf_r_address = cmd_q.dst;
                        rf_w_address = cmd_q.dst;
                        rf_data      = cmd_q.imm;
                    end
                    OP_READ: begin
                        rf_r_address = cmd_q.src;
                        rf_w_address = cmd_q.src;
                    end
                    OP_MOVE: begin
                        rf_r_address = cmd_q.src;
                        rf_w_address = cmd_q.dst;
                    end
                    OP_SWAP: begin
                        rf_r_address = cmd_q.src;
                        rf_w_address = cmd_q.src;
                        state_next   = SWAP_B;
                    end
                endcase
            end
            SWAP_B: begin
                rf_r_address = cmd_q.dst;
                rf_w_address = cmd_q.dst;
                rf_data      = tmp;
                state_next   = SWAP_C;
            end
            SWAP_C: begin
                rf_r_address = cmd_q.src;
                rf_w_address = cmd_q.src;
                rf_data      = rsp_data_q;
                state_next   = RESP;
            end
            RESP: if (host.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign host.cmd_ready = (state == IDLE);
    assign host.rsp_valid = (state == RESP);
    assign host.rsp_data  = rsp_data_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Directed bench for regfile_cmd_ctrl with a behavioural 4x4 register file
// (written every edge, cleared by the shared rst_n, preloadable with 1,2,3,4).
module tb_regfile_cmd_ctrl;
    localparam int DW = 4;
    localparam int AW = 2;

    logic          clk;
    logic          rst_n;
    logic          busy;
    logic [AW-1:0] rf_r_address;
    logic [AW-1:0] rf_w_address;
    logic [DW-1:0] rf_data;
    logic [DW-1:0] rf_q;
    logic          preload;
    logic [DW-1:0] mem [4];

    int total = 0;
    int bad   = 0;

    regfile_cmd_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    regfile_cmd_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host         (bus),
        .busy         (busy),
        .rf_r_address (rf_r_address),
        .rf_w_address (rf_w_address),
        .rf_data      (rf_data),
        .rf_q         (rf_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else if (preload) begin
            mem[0] <= 4'h1; mem[1] <= 4'h2; mem[2] <= 4'h3; mem[3] <= 4'h4;
        end else begin
            mem[rf_w_address] <= rf_data;
        end
    end
    assign rf_q = mem[rf_r_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_file(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [3:0] e3);
        check({tag, "_r0"}, 32'(mem[0]), 32'(e0));
        check({tag, "_r1"}, 32'(mem[1]), 32'(e1));
        check({tag, "_r2"}, 32'(mem[2]), 32'(e2));
        check({tag, "_r3"}, 32'(mem[3]), 32'(e3));
    endtask

    task automatic do_preload();
        @(negedge clk) preload = 1'b1;
        @(negedge clk) preload = 1'b0;
    endtask

    // Issue one command, measure edges from accept to rsp_valid, optionally stall the
    // response (with a competing command on the bus), then complete the handshake.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [1:0] src,
                          input logic [1:0] dst, input logic [3:0] imm, input int exp_lat,
                          input logic [3:0] exp_data, input int stall);
        int lat;
        @(negedge clk);
        check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_src   = src;
        bus.cmd_dst   = dst;
        bus.cmd_imm   = imm;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_data));
        if (stall > 0) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'b00;
            bus.cmd_dst   = 2'd1;
            bus.cmd_imm   = 4'hF;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
                check({tag, "_hold_data"}, 32'(bus.rsp_data), 32'(exp_data));
                check({tag, "_hold_ready"}, 32'(bus.cmd_ready), 32'd0);
            end
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
        @(negedge clk) bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check({tag, "_idle"}, 32'({bus.cmd_ready, bus.rsp_valid, busy}), 32'b100);
    endtask

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        preload       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        bus.cmd_imm   = '0;
        bus.rsp_ready = 1'b0;

        #12;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'({rf_r_address, rf_w_address}), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_preload();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ready", 32'(bus.cmd_ready), 32'd1);
        end
        check_file("idle", 4'h1, 4'h2, 4'h3, 4'h4);

        do_cmd("wr_r2", 2'b00, 2'd0, 2'd2, 4'hA, 1, 4'hA, 0);
        do_cmd("rd_r2", 2'b01, 2'd2, 2'd0, 4'h0, 1, 4'hA, 0);
        check_file("after_wr", 4'h1, 4'h2, 4'hA, 4'h4);

        do_cmd("wr_r0", 2'b00, 2'd0, 2'd0, 4'h5, 1, 4'h5, 0);
        do_cmd("mv_2_3", 2'b10, 2'd2, 2'd3, 4'h0, 1, 4'hA, 0);
        do_cmd("rd_r3", 2'b01, 2'd3, 2'd0, 4'h0, 1, 4'hA, 0);
        check_file("after_mv", 4'h5, 4'h2, 4'hA, 4'hA);

        do_cmd("swap_0_3", 2'b11, 2'd0, 2'd3, 4'h0, 3, 4'hA, 0);
        check_file("after_swap", 4'hA, 4'h2, 4'hA, 4'h5);

        do_cmd("stall_rd_r1", 2'b01, 2'd1, 2'd0, 4'h0, 1, 4'h2, 5);
        check_file("after_stall", 4'hA, 4'h2, 4'hA, 4'h5);

        // SWAP r1<->r2, reset once the controller sits in SWAP_C
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        bus.cmd_src   = 2'd1;
        bus.cmd_dst   = 2'd2;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("swapc_busy", 32'({busy, bus.rsp_valid}), 32'b10);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.cmd_ready), 32'd1);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check_file("midrst", 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk) rst_n = 1'b1;

        do_preload();
        do_cmd("swap_1_1", 2'b11, 2'd1, 2'd1, 4'h0, 3, 4'h2, 0);
        check_file("after_swap_same", 4'h1, 4'h2, 4'h3, 4'h4);
        do_cmd("mv_2_2", 2'b10, 2'd2, 2'd2, 4'h0, 1, 4'h3, 0);
        check_file("after_mv_same", 4'h1, 4'h2, 4'h3, 4'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
